// File: rtl/instruction_fetch_pkg.sv
// Shared types for the z8 fetch path: instruction/address words and the FIFO entry layout.
package instruction_set;

    typedef logic [39:0] instr_t;
    typedef logic [15:0] addr_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

    localparam int PROG_DEPTH_DEFAULT  = 256;
    localparam int FETCH_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO with flush; head is read straight from registered storage.
module fetch_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the z8 core: pc register, push/pop/redirect arbitration around fetch_fifo.
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
module instruction_fetch
    import instruction_set::*;
#(
    parameter int    FETCH_DEPTH = FETCH_DEPTH_DEFAULT,
    parameter int    PROG_DEPTH  = PROG_DEPTH_DEFAULT,
    parameter addr_t RESET_PC    = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fetch_en,
    output logic [15:0]  pc,
    input  logic [39:0]  fetch_instr,
    input  logic         redirect_valid,
    input  logic [15:0]  redirect_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [39:0]  instr_data,
    output logic [15:0]  instr_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall
`endif
);

    localparam int            CW         = $clog2(FETCH_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FETCH_DEPTH);
    localparam addr_t         LAST_PC    = addr_t'(PROG_DEPTH - 1);

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  tail;
    logic          push;
    logic          pop;
    addr_t         redirect_target;

    // A redirect suppresses both sides of the FIFO for the cycle it is asserted.
    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready & ~redirect_valid;
    assign push        = fetch_en & ~redirect_valid & ((count < FULL_COUNT) | pop);

    assign redirect_target = addr_t'(32'(redirect_pc) % 32'(PROG_DEPTH));
    assign tail            = '{pc: pc, instr: fetch_instr};

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_target;
        end else if (push) begin
            pc <= (pc == LAST_PC) ? '0 : pc + 16'd1;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FETCH_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (tail),
        .count (count),
        .head  (head)
    );

    assign instr_data = head.instr;
    assign instr_pc   = head.pc;

`ifdef IFETCH_PERF_EN
    logic stall;

    // A stall is a cycle where fetch wanted to run but the FIFO was full and not draining.
    assign stall = fetch_en & ~redirect_valid & (count == FULL_COUNT) & ~pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table plus randomized traffic
// checked against a queue-based reference model of the fetch stage.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [15:0] pc;
    logic [39:0] fetch_instr;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [39:0] instr_data;
    logic [15:0] instr_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    logic [39:0] prog_mem [256];
    int          checks   = 0;
    int          failures = 0;

    // Reference model state: buffered {pc, instr} entries, fetch address, perf counters.
    logic [55:0] mq[$];
    int          mpc;
    int unsigned mfetched;
    int unsigned mstall;

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rv;
        logic [15:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [15:0] exp_ipc;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign fetch_instr = prog_mem[pc[7:0]];

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .pc             (pc),
        .fetch_instr    (fetch_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the same cycle, then sample after the edge.
    task automatic applyStimulus(input logic rst, input logic fe, input logic rv,
                                 input logic [15:0] rpc, input logic rdy);
        bit mpop;
        bit mpush;
        bit full;
        reset          = rst;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        if (!rst) begin
            mq.delete();
            mpc      = 0;
            mfetched = 0;
            mstall   = 0;
        end else if (rv) begin
            mq.delete();
            mpc = int'(rpc) % 256;
        end else begin
            mpop  = (mq.size() != 0) && rdy;
            full  = (mq.size() >= 2);
            mpush = fe && (!full || mpop);
            if (fe && full && !mpop) mstall++;
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                mq.push_back({16'(mpc), prog_mem[mpc]});
                mpc = (mpc + 1) % 256;
                mfetched++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".valid"}, 64'(instr_valid), 64'(mq.size() != 0));
        chk({tag, ".pc"}, 64'(pc), 64'(mpc));
        if (mq.size() != 0) begin
            chk({tag, ".instr_pc"}, 64'(instr_pc), 64'(mq[0][55:40]));
            chk({tag, ".instr_data"}, 64'(instr_data), 64'(mq[0][39:0]));
        end
`ifdef IFETCH_PERF_EN
        chk({tag, ".perf_fetched"}, 64'(perf_fetched), 64'(mfetched));
        chk({tag, ".perf_stall"}, 64'(perf_stall), 64'(mstall));
`endif
    endtask

    task automatic addVec(input logic rst, input logic fe, input logic rv, input logic [15:0] rpc,
                          input logic rdy, input logic ev, input logic [15:0] eipc,
                          input logic [15:0] epc);
        vec_t v;
        v = '{rst: rst, fe: fe, rv: rv, rpc: rpc, rdy: rdy,
              exp_valid: ev, exp_ipc: eipc, exp_pc: epc};
        vecs.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            prog_mem[i] = {24'hABCDEF ^ 24'(i * 37), 16'(i)};
        end
        reset          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        mq.delete();
        mpc      = 0;
        mfetched = 0;
        mstall   = 0;

        // reset, then stall with instr_ready low: two pushes then three stalled cycles
        addVec(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000);
        addVec(1, 1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0001);
        addVec(1, 1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0002);
        addVec(1, 1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0002);
        addVec(1, 1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0002);
        addVec(1, 1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0002);
        // release: in-order stream with simultaneous push/pop at full
        addVec(1, 1, 0, 16'h0000, 1, 1, 16'h0001, 16'h0003);
        addVec(1, 1, 0, 16'h0000, 1, 1, 16'h0002, 16'h0004);
        addVec(1, 1, 0, 16'h0000, 1, 1, 16'h0003, 16'h0005);
        // halt: drain both entries, pc holds; then resume
        addVec(1, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h0005);
        addVec(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0005);
        addVec(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0005);
        addVec(1, 1, 0, 16'h0000, 1, 1, 16'h0005, 16'h0006);
        // fill, then redirect with upper bits set while full and ready
        addVec(1, 1, 0, 16'h0000, 0, 1, 16'h0005, 16'h0007);
        addVec(1, 1, 1, 16'h0140, 1, 0, 16'h0000, 16'h0040);
        addVec(1, 1, 0, 16'h0000, 1, 1, 16'h0040, 16'h0041);
        // pc wrap at the end of program memory
        addVec(1, 1, 1, 16'h00FE, 1, 0, 16'h0000, 16'h00FE);
        addVec(1, 1, 0, 16'h0000, 1, 1, 16'h00FE, 16'h00FF);
        addVec(1, 1, 0, 16'h0000, 1, 1, 16'h00FF, 16'h0000);
        addVec(1, 1, 0, 16'h0000, 1, 1, 16'h0000, 16'h0001);
        addVec(1, 1, 0, 16'h0000, 1, 1, 16'h0001, 16'h0002);
        // fill, stall, then reset mid-stream and restart
        addVec(1, 1, 0, 16'h0000, 0, 1, 16'h0001, 16'h0003);
        addVec(1, 1, 0, 16'h0000, 0, 1, 16'h0001, 16'h0003);
        addVec(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        addVec(1, 1, 0, 16'h0000, 1, 1, 16'h0000, 16'h0001);

        $display("[TB] directed vectors: %0d", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            chk($sformatf("vec%0d.valid", i), 64'(instr_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.pc", i), 64'(pc), 64'(vecs[i].exp_pc));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d.instr_pc", i), 64'(instr_pc), 64'(vecs[i].exp_ipc));
            end
            if (!vecs[i].rst) begin
                chk($sformatf("vec%0d.rst_data", i), 64'(instr_data), 64'(0));
                chk($sformatf("vec%0d.rst_ipc", i), 64'(instr_pc), 64'(0));
            end
            checkOutput($sformatf("vec%0d.model", i));
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic        r_rst;
            logic        r_fe;
            logic        r_rv;
            logic        r_rdy;
            logic [15:0] r_rpc;
            r_rst = ($urandom_range(0, 99) >= 2);
            r_fe  = ($urandom_range(0, 99) < 80);
            r_rv  = ($urandom_range(0, 99) < 8);
            r_rdy = ($urandom_range(0, 99) < 60);
            r_rpc = 16'($urandom);
            applyStimulus(r_rst, r_fe, r_rv, r_rpc, r_rdy);
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
